pwm_multi_ch: RTL and testbench

//   Multi-channel PWM generator: one shared period counter drives CHANNELS compare outputs.

---
 rtl/pwm_multi_ch_pkg.sv | 15 +
 rtl/pwm_multi_ch_if.sv | 26 ++
 rtl/pwm_multi_ch_cmp.sv | 33 +++
 rtl/pwm_multi_ch.sv | 116 +++++++++++
 tb/tb_pwm_multi_ch.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/pwm_multi_ch_pkg.sv
// Shared constants for the multi-channel PWM block: mode encoding and the
// counter direction type, which doubles as the state of the counter FSM.
// No ports; imported by the top-level module.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Counter direction. DIR_DOWN is only ever reached in center-aligned mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Control/status bundle between register logic and the PWM block.
// master: control side drives enable/load/mode/period/duty, reads outputs.
// slave:  PWM block reads control, drives pwm_out/period_end/pending.
interface pwm_multi_ch_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic                      enable;
    logic                      load;
    logic                      mode;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_end;
    logic                      pending;

    modport master (
        output enable, load, mode, period, duty,
        input  pwm_out, period_end, pending
    );

    modport slave (
        input  enable, load, mode, period, duty,
        output pwm_out, period_end, pending
    );
endinterface

// File: rtl/pwm_multi_ch_cmp.sv
// One PWM channel: active duty register (updated on the apply strobe) and a
// registered compare against the shared counter; output lags cnt_i by 1 cycle.
// Ports: clk, rst, cnt_i, run_i, apply_i, shadow_duty_i in; pwm_o out.
module pwm_ch_cmp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             run_i,
    input  logic             apply_i,
    input  logic [WIDTH-1:0] shadow_duty_i,
    output logic             pwm_o
);
    logic [WIDTH-1:0] duty_act_q;
    logic             pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            // Compare uses the duty active in this cycle; a newly applied
            // duty only affects the first sample of the next period.
            pwm_q <= run_i && (cnt_i < duty_act_q);
            if (apply_i) begin
                duty_act_q <= shadow_duty_i;
            end
        end
    end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared edge/center-aligned period counter with
// double-buffered period/duty/mode applied only at period boundaries.
// Ports: clk, rst (sync, active-high), bus (slave modport of pwm_multi_ch_if).
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic           clk,
    input  logic           rst,
    pwm_multi_ch_if.slave  bus
);
    logic [WIDTH-1:0]          cnt_q;
    dir_e                      dir_q;
    logic [WIDTH-1:0]          per_act_q;
    logic [WIDTH-1:0]          per_sh_q;
    logic                      mode_act_q;
    logic                      mode_sh_q;
    logic [CHANNELS*WIDTH-1:0] duty_sh_q;
    logic                      pending_q;
    logic                      period_end_q;
    logic [CHANNELS-1:0]       pwm_q;

    logic                      run;
    logic [WIDTH-1:0]          per_last;
    logic                      terminal;
    logic                      boundary;
    logic                      apply;

    always_comb begin
        run      = bus.enable && (per_act_q != '0);
        // per_last wraps when per_act_q==0, but that case is idle (run=0)
        // and boundary is forced, so the wrapped value is never used.
        per_last = per_act_q - WIDTH'(1);
        if (mode_act_q == MODE_CENTER) begin
            terminal = (dir_q == DIR_DOWN) && (cnt_q == '0);
        end else begin
            terminal = (cnt_q == per_last);
        end
        // Idle cycles count as boundaries so a pending load lands at once.
        boundary = !run || terminal;
        apply    = boundary && pending_q;
    end

    // Counter / direction FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            period_end_q <= 1'b0;
        end else begin
            period_end_q <= run && terminal;
            if (boundary) begin
                cnt_q <= '0;
                dir_q <= DIR_UP;
            end else begin
                case (dir_q)
                    DIR_UP: begin
                        // Only center mode reaches the top here; the top
                        // count is held one extra cycle while turning round.
                        if (cnt_q == per_last) begin
                            dir_q <= DIR_DOWN;
                        end else begin
                            cnt_q <= cnt_q + WIDTH'(1);
                        end
                    end
                    DIR_DOWN: cnt_q <= cnt_q - WIDTH'(1);
                    default:  dir_q <= DIR_UP;
                endcase
            end
        end
    end

    // Shadow/active registers. On a load coinciding with apply, the active
    // set takes the old shadow and the new values stay pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_act_q  <= '0;
            per_sh_q   <= '0;
            mode_act_q <= MODE_EDGE;
            mode_sh_q  <= MODE_EDGE;
            duty_sh_q  <= '0;
            pending_q  <= 1'b0;
        end else begin
            if (apply) begin
                per_act_q  <= per_sh_q;
                mode_act_q <= mode_sh_q;
            end
            if (bus.load) begin
                per_sh_q  <= bus.period;
                mode_sh_q <= bus.mode;
                duty_sh_q <= bus.duty;
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_ch_cmp #(.WIDTH(WIDTH)) u_cmp (
            .clk           (clk),
            .rst           (rst),
            .cnt_i         (cnt_q),
            .run_i         (run),
            .apply_i       (apply),
            .shadow_duty_i (duty_sh_q[g*WIDTH +: WIDTH]),
            .pwm_o         (pwm_q[g])
        );
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.period_end = period_end_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized check of pwm_multi_ch against a period-position reference model.
module tb_pwm_multi_ch;
    localparam int W = 16;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_multi_ch_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    pwm_multi_ch #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: position t within the current period; counter value
    // derived from t (ramp up, then mirrored ramp down in center mode).
    int m_pa, m_ps, m_ma, m_ms, m_pend, m_t;
    int m_da[C];
    int m_ds[C];

    task automatic model_reset();
        m_pa = 0; m_ps = 0; m_ma = 0; m_ms = 0; m_pend = 0; m_t = 0;
        for (int i = 0; i < C; i++) begin
            m_da[i] = 0;
            m_ds[i] = 0;
        end
    endtask

    // One clock: advance, then compare DUT outputs with model predictions.
    task automatic cyc();
        logic [C-1:0] e_pwm;
        logic         e_pe;
        int len, c;
        bit run, bnd, ap;
        @(posedge clk);
        #1;
        e_pwm = '0;
        e_pe  = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            run = bus.enable && (m_pa != 0);
            len = m_ma ? 2 * m_pa : m_pa;
            c   = (m_ma != 0 && m_t >= m_pa) ? (2 * m_pa - 1 - m_t) : m_t;
            for (int i = 0; i < C; i++) e_pwm[i] = run && (c < m_da[i]);
            e_pe = run && (m_t == len - 1);
            bnd  = !run || (m_t == len - 1);
            ap   = bnd && (m_pend != 0);
            m_t  = bnd ? 0 : m_t + 1;
            if (ap) begin
                m_pa = m_ps;
                m_ma = m_ms;
                for (int i = 0; i < C; i++) m_da[i] = m_ds[i];
            end
            if (bus.load) begin
                m_ps = int'(bus.period);
                m_ms = int'(bus.mode);
                for (int i = 0; i < C; i++) m_ds[i] = int'(bus.duty[i*W +: W]);
                m_pend = 1;
            end else if (ap) begin
                m_pend = 0;
            end
        end
        chk("pwm_out", 32'(bus.pwm_out), 32'(e_pwm));
        chk("period_end", 32'(bus.period_end), 32'(e_pe));
        chk("pending", 32'(bus.pending), 32'(m_pend != 0));
    endtask

    task automatic drive_load(input logic md, input int per, input int d3, input int d2,
                              input int d1, input int d0);
        bus.load   = 1'b1;
        bus.mode   = md;
        bus.period = W'(per);
        bus.duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic random_run(input int n, input int off_mod, input int load_mod, input int rst_mod);
        for (int k = 0; k < n; k++) begin
            rst        = ($urandom_range(0, rst_mod - 1) == 0);
            bus.enable = ($urandom_range(0, off_mod - 1) != 0);
            bus.load   = ($urandom_range(0, load_mod - 1) == 0);
            bus.mode   = 1'($urandom_range(0, 1));
            bus.period = W'($urandom_range(0, 6));
            for (int i = 0; i < C; i++) bus.duty[i*W +: W] = W'($urandom_range(0, 7));
            cyc();
        end
        rst      = 1'b0;
        bus.load = 1'b0;
    endtask

    initial begin
        model_reset();
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.mode   = 1'b0;
        bus.period = '0;
        bus.duty   = '0;
        cyc();
        cyc();
        chk("rst_pwm_out", 32'(bus.pwm_out), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        rst        = 1'b0;
        bus.enable = 1'b1;
        cyc();

        // Edge basics: P=4, duty {4,3,1,0}.
        drive_load(1'b0, 4, 4, 3, 1, 0);
        repeat (12) cyc();
        // Center mode: P=4, D0=1.
        drive_load(1'b1, 4, 0, 0, 0, 1);
        repeat (20) cyc();
        // Duty above period, then P=0.
        drive_load(1'b0, 4, 0, 0, 0, 5);
        repeat (10) cyc();
        drive_load(1'b0, 0, 1, 1, 1, 1);
        repeat (6) cyc();

        random_run(3000, 16, 8, 200);
        random_run(3000, 64, 20, 500);
        random_run(1000, 4, 3, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
